// File: rtl/mdu_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit:
// request, operands and direct HI/LO writes in, busy flag and HI/LO out.
interface mdu_if;
  logic        start;
  logic [1:0]  mdu_op;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdu_op, hi_write, lo_write, a, b,
                  input  busy, hi, lo);
  modport slave  (input  start, mdu_op, hi_write, lo_write, a, b,
                  output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO registers; the result is
// computed when start is sampled and committed when the busy countdown expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  count;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pending_hi, pending_lo;
  logic        pending_we;

  logic        div_zero, div_ovf;
  logic [31:0] sdiv_b, udiv_b;
  logic [63:0] mul_s, mul_u;
  logic [31:0] sq, sr, uq, ur;
  logic [31:0] res_hi, res_lo;

  // Divisors are forced to 1 for zero and for INT_MIN / -1; the latter then
  // yields exactly quotient INT_MIN, remainder 0, and zero divides never commit.
  always_comb begin
    div_zero = (bus.b == 32'd0);
    div_ovf  = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    sdiv_b   = (div_zero || div_ovf) ? 32'd1 : bus.b;
    udiv_b   = div_zero ? 32'd1 : bus.b;
    mul_s    = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    mul_u    = {32'd0, bus.a} * {32'd0, bus.b};
    sq       = $signed(bus.a) / $signed(sdiv_b);
    sr       = $signed(bus.a) % $signed(sdiv_b);
    uq       = bus.a / udiv_b;
    ur       = bus.a % udiv_b;
  end

  always_comb begin
    res_hi = mul_s[63:32];
    res_lo = mul_s[31:0];
    case (bus.mdu_op)
      2'b00: begin res_hi = mul_s[63:32]; res_lo = mul_s[31:0]; end
      2'b01: begin res_hi = mul_u[63:32]; res_lo = mul_u[31:0]; end
      2'b10: begin res_hi = sr;           res_lo = sq;          end
      2'b11: begin res_hi = ur;           res_lo = uq;          end
      default: ;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.hi_write) hi_q <= bus.a;
          if (bus.lo_write) lo_q <= bus.a;
          if (bus.start) begin
            state      <= RUN;
            count      <= bus.mdu_op[1] ? DIV_LOAD : MULT_LOAD;
            pending_hi <= res_hi;
            pending_lo <= res_lo;
            pending_we <= !(bus.mdu_op[1] && div_zero);
          end
        end
        RUN: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= IDLE;
            if (pending_we) begin
              hi_q <= pending_hi;
              lo_q <= pending_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, each opcode, divide corner cases,
// busy-time protection, operand hold and back-to-back issue.
module tb_mult_div_unit;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n;

  mdu_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.a      = a;
    bus.b      = b;
    tick();
    bus.start  = 1'b0;
  endtask

  // Counts cycles from the start edge until busy drops, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.mdu_op   = 2'b00;
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    rst          = 1'b1;
    tick();
    tick();
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    rst = 1'b0;
    tick();

    // Reset mid-run: asynchronous, clears busy and cancels the commit.
    start_op(2'b00, 32'd3, 32'd4);
    check("midrst_busy_on", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("midrst_nocommit_lo", bus.lo, 32'd0);
    check("midrst_idle", {31'd0, bus.busy}, 32'd0);

    // Signed mult -2 * 3; HI/LO hold old values until commit.
    start_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_on", {31'd0, bus.busy}, 32'd1);
    tick();
    check("mult_hold_lo", bus.lo, 32'd0);
    n = 1;
    while (bus.busy && n < 40) begin tick(); n++; end
    check("mult_cycles", n, 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    start_op(2'b01, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", bus.hi, 32'h0000_0002);
    check("multu_lo", bus.lo, 32'hFFFF_FFFA);

    // Signed divides: truncation toward zero, remainder follows dividend.
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    start_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done(n);
    check("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_negb_hi", bus.hi, 32'd1);

    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'd0);

    start_op(2'b11, 32'd100, 32'd7);
    wait_done(n);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    // Direct writes, then divide by zero leaves them untouched.
    bus.hi_write = 1'b1;
    bus.a        = 32'h11;
    tick();
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b1;
    bus.a        = 32'h22;
    tick();
    bus.lo_write = 1'b0;
    check("mthi", bus.hi, 32'h11);
    check("mtlo", bus.lo, 32'h22);
    start_op(2'b11, 32'd5, 32'd0);
    wait_done(n);
    check("divz_cycles", n, 32'd10);
    check("divz_hi", bus.hi, 32'h11);
    check("divz_lo", bus.lo, 32'h22);

    // Busy-time protection: mthi and a new start during a multu are dropped.
    start_op(2'b01, 32'h0001_0000, 32'h0003_0000);
    tick();
    bus.hi_write = 1'b1;
    bus.start    = 1'b1;
    bus.mdu_op   = 2'b11;
    bus.a        = 32'hDEAD;
    bus.b        = 32'd1;
    tick();
    bus.hi_write = 1'b0;
    bus.start    = 1'b0;
    check("prot_hi_hold", bus.hi, 32'h11);
    n = 2;
    while (bus.busy && n < 40) begin tick(); n++; end
    check("prot_cycles", n, 32'd5);
    check("prot_hi", bus.hi, 32'd3);
    check("prot_lo", bus.lo, 32'd0);

    // Operand hold: A/B wander after start; result uses the sampled pair.
    start_op(2'b00, 32'd7, 32'd6);
    n = 0;
    while (bus.busy && n < 40) begin
      bus.a = 32'd100 + n;
      bus.b = 32'd200 + n;
      tick();
      n++;
    end
    check("hold_cycles", n, 32'd5);
    check("hold_lo", bus.lo, 32'd42);
    check("hold_hi", bus.hi, 32'd0);

    // Back-to-back start the first cycle after busy falls.
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_busy_on", {31'd0, bus.busy}, 32'd1);
    check("b2b_prev_lo", bus.lo, 32'd42);
    wait_done(n);
    check("b2b_cycles", n, 32'd5);
    check("b2b_lo", bus.lo, 32'd1);
    check("b2b_hi", bus.hi, 32'd0);

    // Start together with mthi: direct write lands now, commit overwrites later.
    bus.hi_write = 1'b1;
    start_op(2'b00, 32'd5, 32'd9);
    bus.hi_write = 1'b0;
    check("sim_mthi_hi", bus.hi, 32'd5);
    check("sim_mthi_lo", bus.lo, 32'd1);
    wait_done(n);
    check("sim_commit_hi", bus.hi, 32'd0);
    check("sim_commit_lo", bus.lo, 32'd45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide responder for the Execute stage. It accepts a one-cycle Start with an opcode and two operands, then holds Busy high for a fixed multi-cycle latency.
- On completion it commits the 64-bit result to the HI/LO architectural registers.
- It also services direct HI/LO writes (mthi/mtlo).
- HI and LO are read combinationally by the Execute-stage writeback mux (mfhi/mflo). The hazard unit stalls decode while Start or Busy is high.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, Busy duration in cycles for div/divu (legal range 1..15).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request; sampled at the rising edge.
- MDUOp  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu; valid only with Start.
- HIWrite  input  1  mthi: write A into HI.
- LOWrite  input  1  mtlo: write A into LO.
- A  input  32  operand rs (forwarded value).
- B  input  32  operand rt (forwarded value).
- Busy  output  1  operation in progress.
- HI  output  32  HI register (product high word / remainder).
- LO  output  32  LO register (product low word / quotient).

Behaviour:
- Reset, asynchronous and immediate:
  - HI=0, LO=0, Busy=0.
  - Cycle counter=0; pending result registers=0.
  - An operation in flight is discarded and HI/LO are not updated.
- State machine has two states:
  - IDLE, counter==0, Busy=0.
  - RUN, counter!=0, Busy=1.
  - Busy is a registered output equal to (counter!=0).
- IDLE to RUN: at an edge with Start=1.
  - Counter loads MULT_CYCLES when MDUOp[1]==0, else DIV_CYCLES.
  - The result is computed from A, B, MDUOp at that edge and latched into pending_hi/pending_lo. Later changes on A/B have no effect.
- RUN: counter decrements each edge. At the edge where counter goes 1 to 0, HI<=pending_hi and LO<=pending_lo, and Busy falls at the same edge.
- Latency: Start sampled at edge k means Busy=1 during cycles k..k+N-1 (after edge k through edge k+N). The new HI/LO are visible after edge k+N.
- Arithmetic:
  - mult: signed 32x32 to 64; {HI,LO}=product.
  - multu: unsigned 32x32 to 64.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend A.
    - Special case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: LO=A/B, HI=A%B, both unsigned.
- Divide by zero (B==0 on div/divu): the operation runs the full DIV_CYCLES with Busy asserted, but HI and LO are left unchanged at commit.
- Direct writes, accepted only when Busy=0:
  - HIWrite: HI<=A at the edge.
  - LOWrite: LO<=A at the edge.
  - Both may assert in the same cycle.
- Ignored inputs:
  - Start, HIWrite and LOWrite while Busy=1 have no effect. The stall logic guarantees this never happens; verification must still check it.
  - MDUOp, A and B are ignored when Start=0.
- Simultaneous Start and HIWrite/LOWrite in IDLE:
  - The direct write updates HI/LO immediately.
  - The operation starts normally and its commit later overwrites both registers.
- Back-to-back: a Start in the first cycle after Busy falls is accepted. HI/LO already hold the previous result.
- HI and LO change only at reset, commit edges, and direct-write edges.

Test Plan:
- Reset mid-run: Start mult A=3, B=4; assert Reset at cycle 2 -> Busy=0 immediately; HI=0, LO=0; no later commit.
- Signed mult: Start MDUOp=00, A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed div: MDUOp=10, A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Overflow case A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via HIWrite/LOWrite; divu A=5, B=0 -> Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- Busy-time protection: during a multu, pulse HIWrite with A=0xDEAD and Start with divu -> both ignored; Busy still falls after 5 cycles; result equals the original multu result.
- Operand hold and back-to-back: change A/B every cycle after Start; result reflects the sampled operands. Start a second mult the cycle after Busy falls -> Busy re-asserts for 5 cycles; first result visible in between.
